// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester handshake, result return and ALU pin bundle for alu_arbiter.
// Lock0/Lock1 exist only when ALU_ARB_LOCK_EN is defined.
interface alu_arbiter_if #(
  parameter int unsigned W   = 8,
  parameter int unsigned Ops = 4
);
  // Requester 0
  logic           Req0;
  logic [Ops-1:0] Op0;
  logic [W-1:0]   A0;
  logic [W-1:0]   B0;
  logic [4:0]     Imm0;
  logic [2:0]     Loop0;
  // Requester 1
  logic           Req1;
  logic [Ops-1:0] Op1;
  logic [W-1:0]   A1;
  logic [W-1:0]   B1;
  logic [4:0]     Imm1;
  logic [2:0]     Loop1;
`ifdef ALU_ARB_LOCK_EN
  logic           Lock0;
  logic           Lock1;
`endif
  // Completion and captured result
  logic           Done0;
  logic           Done1;
  logic [W-1:0]   Result;
  logic [2:0]     Flags;
  // ALU pins
  logic [W-1:0]   AluA;
  logic [W-1:0]   AluB;
  logic [4:0]     AluImm;
  logic [2:0]     AluLoop;
  logic [Ops-1:0] AluOp;
  logic           AluSC;
  logic [W-1:0]   AluOut;
  logic           AluZero;
  logic           AluParity;
  logic           AluOdd;

  // Arbiter side
  modport slave (
    input  Req0, Op0, A0, B0, Imm0, Loop0,
    input  Req1, Op1, A1, B1, Imm1, Loop1,
`ifdef ALU_ARB_LOCK_EN
    input  Lock0, Lock1,
`endif
    output Done0, Done1, Result, Flags,
    output AluA, AluB, AluImm, AluLoop, AluOp, AluSC,
    input  AluOut, AluZero, AluParity, AluOdd
  );

  // Requesters plus ALU side
  modport master (
    output Req0, Op0, A0, B0, Imm0, Loop0,
    output Req1, Op1, A1, B1, Imm1, Loop1,
`ifdef ALU_ARB_LOCK_EN
    output Lock0, Lock1,
`endif
    input  Done0, Done1, Result, Flags,
    input  AluA, AluB, AluImm, AluLoop, AluOp, AluSC,
    output AluOut, AluZero, AluParity, AluOdd
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters.
// Each op runs IDLE (grant/latch) -> ISSUE (ALU driven) -> DONE (one-cycle Done pulse).
// Optional macro ALU_ARB_LOCK_EN: Lock0/Lock1 keep the grant with the served requester
// for atomic sequences, bounded to 4 consecutive grants.
module alu_arbiter #(
  parameter int unsigned W   = 8,
  parameter int unsigned Ops = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  alu_arbiter_if.slave bus
);

  localparam int unsigned IMM_W  = 5;
  localparam int unsigned LOOP_W = 3;
  localparam int unsigned FLAG_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                ptr;
  logic                ptr_nxt;
  logic                gnt;
  logic                gnt_nxt;
  logic                load_c;
  logic                capture_c;
  logic                done0_nxt;
  logic                done1_nxt;

  logic                done0_q;
  logic                done1_q;
  logic [W-1:0]        result_q;
  logic [FLAG_W-1:0]   flags_q;
  logic [W-1:0]        alu_a_q;
  logic [W-1:0]        alu_b_q;
  logic [IMM_W-1:0]    alu_imm_q;
  logic [LOOP_W-1:0]   alu_loop_q;
  logic [Ops-1:0]      alu_op_q;

`ifdef ALU_ARB_LOCK_EN
  localparam int unsigned       CNT_W    = 3;
  localparam logic [CNT_W-1:0]  LOCK_MAX = CNT_W'(4);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             lock_c;

  // Lock request of whichever requester is currently being served
  assign lock_c = gnt ? bus.Lock1 : bus.Lock0;
`endif

  // Control state: FSM, round-robin pointer, grant owner, Done pulses
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      gnt     <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      cnt     <= '0;
`endif
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt     <= gnt_nxt;
      done0_q <= done0_nxt;
      done1_q <= done1_nxt;
`ifdef ALU_ARB_LOCK_EN
      cnt     <= cnt_nxt;
`endif
    end
  end

  // Next-state, grant selection and register-enable decode
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    load_c    = 1'b0;
    capture_c = 1'b0;
    done0_nxt = 1'b0;
    done1_nxt = 1'b0;
`ifdef ALU_ARB_LOCK_EN
    cnt_nxt   = cnt;
`endif
    case (state)
      IDLE: begin
        if (bus.Req0 || bus.Req1) begin
          gnt_nxt   = (bus.Req0 && bus.Req1) ? ptr : bus.Req1;
          load_c    = 1'b1;
          state_nxt = ISSUE;
`ifdef ALU_ARB_LOCK_EN
          // Count consecutive grants to the same requester; a switch restarts the run
          if (gnt_nxt == gnt) begin
            cnt_nxt = (cnt == '1) ? cnt : cnt + CNT_W'(1);
          end else begin
            cnt_nxt = CNT_W'(1);
          end
`endif
        end
      end
      ISSUE: begin
        capture_c = 1'b1;
        done0_nxt = ~gnt;
        done1_nxt = gnt;
        state_nxt = DONE;
      end
      DONE: begin
        ptr_nxt   = ~gnt;
`ifdef ALU_ARB_LOCK_EN
        if (lock_c && (cnt < LOCK_MAX)) begin
          ptr_nxt = gnt;
        end
`endif
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Issue registers latch the granted operands; result register captures the ALU
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_imm_q  <= '0;
      alu_loop_q <= '0;
      alu_op_q   <= '0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      if (load_c) begin
        if (gnt_nxt) begin
          alu_a_q    <= bus.A1;
          alu_b_q    <= bus.B1;
          alu_imm_q  <= bus.Imm1;
          alu_loop_q <= bus.Loop1;
          alu_op_q   <= bus.Op1;
        end else begin
          alu_a_q    <= bus.A0;
          alu_b_q    <= bus.B0;
          alu_imm_q  <= bus.Imm0;
          alu_loop_q <= bus.Loop0;
          alu_op_q   <= bus.Op0;
        end
      end
      if (capture_c) begin
        result_q <= bus.AluOut;
        flags_q  <= {bus.AluZero, bus.AluParity, bus.AluOdd};
      end
    end
  end

  assign bus.Done0   = done0_q;
  assign bus.Done1   = done1_q;
  assign bus.Result  = result_q;
  assign bus.Flags   = flags_q;
  assign bus.AluA    = alu_a_q;
  assign bus.AluB    = alu_b_q;
  assign bus.AluImm  = alu_imm_q;
  assign bus.AluLoop = alu_loop_q;
  assign bus.AluOp   = alu_op_q;
  assign bus.AluSC   = 1'b0;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized two-requester traffic against a
// transaction-level reference model; a small ALU model closes the loop on the ALU pins.
module tb_alu_arbiter;

  localparam int unsigned W   = 8;
  localparam int unsigned OPS = 4;

  localparam logic [OPS-1:0] OP_ADD = 4'd0;
  localparam logic [OPS-1:0] OP_XOR = 4'd1;
  localparam logic [OPS-1:0] OP_MOV = 4'd2;
  localparam logic [OPS-1:0] OP_SEQ = 4'd3;

  logic Clk = 1'b0;
  logic Reset;

  alu_arbiter_if #(.W(W), .Ops(OPS)) bus ();

  alu_arbiter #(.W(W), .Ops(OPS)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial forever #5 Clk = ~Clk;

  // Requester-side drive values
  logic           r_req  [2];
  logic [OPS-1:0] r_op   [2];
  logic [W-1:0]   r_a    [2];
  logic [W-1:0]   r_b    [2];
  logic [4:0]     r_imm  [2];
  logic [2:0]     r_loop [2];
  logic           r_lock [2];

  assign bus.Req0  = r_req[0];
  assign bus.Op0   = r_op[0];
  assign bus.A0    = r_a[0];
  assign bus.B0    = r_b[0];
  assign bus.Imm0  = r_imm[0];
  assign bus.Loop0 = r_loop[0];
  assign bus.Req1  = r_req[1];
  assign bus.Op1   = r_op[1];
  assign bus.A1    = r_a[1];
  assign bus.B1    = r_b[1];
  assign bus.Imm1  = r_imm[1];
  assign bus.Loop1 = r_loop[1];
`ifdef ALU_ARB_LOCK_EN
  assign bus.Lock0 = r_lock[0];
  assign bus.Lock1 = r_lock[1];
`endif

  // Combinational ALU stand-in
  function automatic logic [W-1:0] alu_f(input logic [OPS-1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [4:0] imm,
                                         input logic [2:0] lp);
    case (op)
      OP_ADD:  return a + W'(lp);
      OP_XOR:  return a ^ b;
      OP_MOV:  return b;
      OP_SEQ:  return (a == W'(imm)) ? W'(1) : W'(0);
      4'd4:    return a - b;
      4'd5:    return a & b;
      4'd6:    return a | b;
      4'd7:    return a + b;
      default: return ~a;
    endcase
  endfunction

  function automatic logic [2:0] flags_f(input logic [W-1:0] v);
    return {(v == '0), ^v, v[0]};
  endfunction

  assign bus.AluOut = alu_f(bus.AluOp, bus.AluA, bus.AluB, bus.AluImm, bus.AluLoop);
  assign {bus.AluZero, bus.AluParity, bus.AluOdd} = flags_f(bus.AluOut);

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Transaction-level reference: an op granted at edge g shows Done in the cycle after
  // edge g+1 and frees the arbiter at edge g+2.
  int             m_cyc      = 0;
  bit             m_busy     = 1'b0;
  int             m_gcyc     = 0;
  int             m_who      = 0;
  int             m_fav      = 0;
  int             m_streak   = 0;
  int             m_last     = -1;
  logic [OPS-1:0] l_op       = '0;
  logic [W-1:0]   l_a        = '0;
  logic [W-1:0]   l_b        = '0;
  logic [4:0]     l_imm      = '0;
  logic [2:0]     l_loop     = '0;
  bit             exp_done [2];
  logic [W-1:0]   exp_res    = '0;
  logic [2:0]     exp_flags  = '0;

  task automatic model_step();
    m_cyc++;
    if (!Reset) begin
      m_busy = 1'b0; m_fav = 0; m_streak = 0; m_last = -1;
      exp_done[0] = 1'b0; exp_done[1] = 1'b0;
      exp_res = '0; exp_flags = '0;
      l_op = '0; l_a = '0; l_b = '0; l_imm = '0; l_loop = '0;
    end else if (m_busy && m_cyc == m_gcyc + 1) begin
      exp_res = alu_f(l_op, l_a, l_b, l_imm, l_loop);
      exp_flags = flags_f(exp_res);
      exp_done[m_who] = 1'b1;
    end else if (m_busy && m_cyc == m_gcyc + 2) begin
      exp_done[0] = 1'b0; exp_done[1] = 1'b0;
      m_busy = 1'b0;
      m_fav = 1 - m_who;
`ifdef ALU_ARB_LOCK_EN
      if (r_lock[m_who] && m_streak < 4) m_fav = m_who;
`endif
    end else if (!m_busy && (r_req[0] || r_req[1])) begin
      m_who = (r_req[0] && r_req[1]) ? m_fav : (r_req[1] ? 1 : 0);
      m_streak = (m_who == m_last) ? m_streak + 1 : 1;
      m_last = m_who;
      m_busy = 1'b1;
      m_gcyc = m_cyc;
      l_op = r_op[m_who]; l_a = r_a[m_who]; l_b = r_b[m_who];
      l_imm = r_imm[m_who]; l_loop = r_loop[m_who];
    end
  endtask

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  // Per-cycle comparison of every DUT output against the model
  initial forever begin
    @(negedge Clk);
    if (chk_en) begin
      check("done0",   32'(bus.Done0),   32'(exp_done[0]));
      check("done1",   32'(bus.Done1),   32'(exp_done[1]));
      check("result",  32'(bus.Result),  32'(exp_res));
      check("flags",   32'(bus.Flags),   32'(exp_flags));
      check("alu_a",   32'(bus.AluA),    32'(l_a));
      check("alu_b",   32'(bus.AluB),    32'(l_b));
      check("alu_imm", 32'(bus.AluImm),  32'(l_imm));
      check("alu_loop",32'(bus.AluLoop), 32'(l_loop));
      check("alu_op",  32'(bus.AluOp),   32'(l_op));
      check("alu_sc",  32'(bus.AluSC),   32'(0));
    end
  end

  task automatic set_req(input int i, input logic r, input logic [OPS-1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] imm, input logic [2:0] lp);
    r_req[i] = r; r_op[i] = op; r_a[i] = a; r_b[i] = b; r_imm[i] = imm; r_loop[i] = lp;
  endtask

  task automatic rand_ops(input int i);
    r_op[i]   = OPS'($urandom_range(0, 15));
    r_a[i]    = W'($urandom);
    r_b[i]    = W'($urandom);
    r_imm[i]  = 5'($urandom);
    r_loop[i] = 3'($urandom);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
  endtask

  // Waits (bounded) for a Done pulse; returns requester id and negedges elapsed
  task automatic wait_done(output int which, output int n);
    which = -1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      n++;
      if (bus.Done0 || bus.Done1) begin
        which = bus.Done1 ? 1 : 0;
        break;
      end
    end
    if (which < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no Done, required one within 20 cycles at t=%0t", $time);
    end
  endtask

  int w;
  int n;

  initial begin
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(i, 1'b0, '0, '0, '0, '0, '0);
      r_lock[i] = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge Clk);
    chk_en = 1'b1;
    check("rst_done0", 32'(bus.Done0), 32'(0));
    check("rst_done1", 32'(bus.Done1), 32'(0));
    check("rst_result", 32'(bus.Result), 32'(0));
    check("rst_flags", 32'(bus.Flags), 32'(0));
    check("rst_alu_op", 32'(bus.AluOp), 32'(0));
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("idle_done", 32'({bus.Done0, bus.Done1}), 32'(0));
    check("idle_result", 32'(bus.Result), 32'(0));

    // Single ADD: 5 + loop 3
    set_req(0, 1'b1, OP_ADD, 8'h05, 8'h00, 5'd0, 3'd3);
    wait_done(w, n);
    check("add_who", 32'(w), 32'(0));
    check("add_latency", 32'(n), 32'(2));
    check("add_result", 32'(bus.Result), 32'(8'h08));
    check("add_flags", 32'(bus.Flags), 32'(3'b010));
    check("add_model", 32'(exp_res), 32'(8'h08));
    r_req[0] = 1'b0;

    // Simultaneous requests after reset: requester 0 first
    do_reset();
    set_req(0, 1'b1, OP_XOR, 8'h0F, 8'hF0, 5'd0, 3'd0);
    set_req(1, 1'b1, OP_MOV, 8'h00, 8'h3C, 5'd0, 3'd0);
    wait_done(w, n);
    check("xor_who", 32'(w), 32'(0));
    check("xor_result", 32'(bus.Result), 32'(8'hFF));
    check("xor_flags", 32'(bus.Flags), 32'(3'b001));
    r_req[0] = 1'b0;
    wait_done(w, n);
    check("mov_who", 32'(w), 32'(1));
    check("mov_gap", 32'(n), 32'(3));
    check("mov_result", 32'(bus.Result), 32'(8'h3C));
    check("mov_flags", 32'(bus.Flags), 32'(3'b000));
    r_req[1] = 1'b0;

    // Continuous contention: strict alternation, one Done every 3 cycles
    do_reset();
    rand_ops(0); rand_ops(1);
    r_req[0] = 1'b1; r_req[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_done(w, n);
      check("rr_who", 32'(w), 32'(k % 2));
      check("rr_gap", 32'(n), 32'((k == 0) ? 2 : 3));
      check("rr_exclusive", 32'(bus.Done0 & bus.Done1), 32'(0));
      if (w >= 0) rand_ops(w);
    end
    r_req[0] = 1'b0; r_req[1] = 1'b0;

    // Reset during ISSUE aborts the op; pointer returns to 0
    do_reset();
    set_req(1, 1'b1, OP_SEQ, 8'h07, 8'h00, 5'd7, 3'd0);
    @(negedge Clk);
    check("abort_issue_done1", 32'(bus.Done1), 32'(0));
    Reset = 1'b0;
    @(negedge Clk);
    check("abort_done1", 32'(bus.Done1), 32'(0));
    check("abort_result", 32'(bus.Result), 32'(0));
    check("abort_flags", 32'(bus.Flags), 32'(0));
    set_req(0, 1'b1, OP_MOV, 8'h00, 8'h55, 5'd0, 3'd0);
    Reset = 1'b1;
    wait_done(w, n);
    check("abort_ptr_who", 32'(w), 32'(0));
    check("abort_ptr_result", 32'(bus.Result), 32'(8'h55));
    r_req[0] = 1'b0;
    wait_done(w, n);
    check("seq_who", 32'(w), 32'(1));
    check("seq_result", 32'(bus.Result), 32'(8'h01));
    check("seq_flags", 32'(bus.Flags), 32'(3'b011));
    r_req[1] = 1'b0;

`ifdef ALU_ARB_LOCK_EN
    // Lock0 held with both requesting: four grants to 0, then one to 1, repeating
    do_reset();
    r_lock[0] = 1'b1;
    rand_ops(0); rand_ops(1);
    r_req[0] = 1'b1; r_req[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_done(w, n);
      check("lock_who", 32'(w), 32'(((k % 5) == 4) ? 1 : 0));
      if (w >= 0) rand_ops(w);
    end
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    r_lock[0] = 1'b0;
`endif

    // Randomized traffic: withdrawals, back-to-back requests, post-grant operand churn, resets
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge Clk);
      Reset = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (exp_done[i]) begin
          if ($urandom_range(0, 1) == 0) r_req[i] = 1'b0;
          else rand_ops(i);
        end else if (!r_req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            r_req[i] = 1'b1;
            rand_ops(i);
          end
        end else if (m_busy && m_who == i) begin
          if ($urandom_range(0, 3) == 0) rand_ops(i);
        end else if ($urandom_range(0, 15) == 0) begin
          r_req[i] = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) r_lock[i] = 1'($urandom_range(0, 1));
      end
    end

    r_req[0] = 1'b0; r_req[1] = 1'b0;
    repeat (4) @(negedge Clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the main decode path and an auxiliary loop/address unit.
- Round-robin arbitration with a Req/Done handshake.
- Each granted operation is latched into issue registers, driven onto the ALU for one cycle, and the ALU result and flags are captured into a result register.
- Sits between the requesters and the ALU instance; no other logic drives the ALU operand or opcode pins.

Parameters:
- W, 8, data width of operands and result.
- Ops, 4, ALU opcode width.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset; sampled on rising Clk.
- Req0  input  1  requester 0 operation request; held high until Done0.
- Op0  input  Ops  requester 0 ALU opcode (Definitions op_mne encoding).
- A0  input  W  requester 0 InputA operand.
- B0  input  W  requester 0 InputB operand.
- Imm0  input  5  requester 0 5-bit immediate.
- Loop0  input  3  requester 0 3-bit immediate.
- Req1, Op1, A1, B1, Imm1, Loop1: same as above, for requester 1.
- Done0  output  1  one-cycle pulse: requester 0 result valid.
- Done1  output  1  one-cycle pulse: requester 1 result valid.
- Result  output  W  captured ALU Out; valid while DoneX is high, held otherwise.
- Flags  output  3  captured {Zero, Parity, Odd}.
- AluA, AluB  output  W  to ALU InputA/InputB.
- AluImm  output  5  to ALU Immediate.
- AluLoop  output  3  to ALU Loop.
- AluOp  output  Ops  to ALU OP.
- AluSC  output  1  to ALU SC_in; constant 0.
- AluOut  input  W  from ALU Out.
- AluZero, AluParity, AluOdd  input  1  from ALU flags.

Behaviour:
- Reset (Reset==0 at edge):
  - State IDLE, round-robin pointer Ptr=0, Done0/Done1=0, Result=0, Flags=0.
  - AluA/AluB/AluImm/AluLoop/AluOp=0.
  - Overrides everything, including an op in flight: no Done is issued for an aborted op.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - No Req: stay IDLE, ALU issue registers hold their last values.
  - One Req high: grant it.
  - Both high: grant requester Ptr.
  - On grant: latch that requester's Op/A/B/Imm/Loop into the issue registers, record Gnt, go ISSUE.
- ISSUE:
  - Issue registers drive the ALU for the full cycle.
  - At the edge: Result<=AluOut, Flags<={AluZero,AluParity,AluOdd}, go DONE.
- DONE:
  - Done[Gnt]=1 for exactly this cycle; the other Done stays 0.
  - At the edge: Ptr<=~Gnt, go IDLE.
- Latency: Req sampled high at edge N → Done high during cycle N+2. Throughput is one op per 3 cycles.
- Handshake rules:
  - Requester holds Req and all operands stable from assertion until Done.
  - Requester deasserts Req at the edge ending its Done cycle, or keeps it high to request a new op, which competes normally in IDLE.
  - Operand changes after the grant edge have no effect, because operands are latched.
  - Req dropped before grant: the request is withdrawn, with no side effects.
- Fairness: after serving X, Ptr points to the other requester. With both requesting continuously, grants alternate 0,1,0,1. Each requester waits at most one foreign op.
- Result/Flags update only at the ISSUE→DONE edge; hold otherwise.
- AluSC is tied 0.
- Opcode values are passed through unchecked; an illegal opcode yields whatever the ALU produces.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- When defined:
  - Adds inputs Lock0/Lock1 (1 bit each).
  - If the served requester's Lock is high during DONE, Ptr is not toggled, and in the following IDLE that requester wins even if the other requests. This allows atomic multi-op sequences.
  - A lock holder is limited to 4 consecutive grants while the other requester waits; the 5th grant goes to the waiter. A 3-bit counter resets on any grant switch.
- When undefined:
  - No Lock ports; pure round-robin as above.

Test Plan:
- Reset low 2 cycles, then high, no Req → Done0=Done1=0, Result=0, Flags=0, state remains IDLE.
- Req0: Op=ADD, A0=8'h05, Loop0=3 → Done0 high exactly 2 cycles after the Req sample edge, Result=8'h08, Flags={0,1,0}.
- Req0 and Req1 raised the same cycle after reset (Ptr=0): Req0 XOR A=8'h0F,B=8'hF0; Req1 MOV B=8'h3C → Done0 first with Result=8'hFF, Flags={0,0,1}; Done1 3 cycles later with Result=8'h3C.
- Both Req held continuously for 6 ops → Done sequence 0,1,0,1,0,1, one Done every 3 cycles, never both high.
- Req1 SEQ A1=8'h07, Imm1=5'd7; Reset pulled low during ISSUE → no Done1, Result=0, Ptr=0; re-request completes with Result=8'h01.
- ALU_ARB_LOCK_EN: Lock0=1, both Req high → 4 consecutive Done0, then Done1, then the counter resets.
